// File: rtl/ans_freq_table.sv
// ans_freq_table: programmable per-symbol frequency table with on-command prefix-sum build.
// Optional feature macro ANS_FREQ_ZERO_CHECK_EN: drop zero-frequency lookups and raise err_zero.
module ans_freq_table #(
  parameter int SYM_WIDTH   = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int STATE_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           cfg_we,
  input  logic [SYM_WIDTH-1:0]           cfg_sym,
  input  logic [CNT_WIDTH-1:0]           cfg_count,
  input  logic                           cfg_commit,
  output logic                           table_ok,
  input  logic [SYM_WIDTH-1:0]           in_sym,
  input  logic                           in_vld,
  output logic                           in_rdy,
  output logic [CNT_WIDTH-1:0]           s_count,
  output logic [SYM_WIDTH+CNT_WIDTH-1:0] s_cumulative,
  output logic [STATE_WIDTH-1:0]         total_count,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic                           err_zero
);
  // state | meaning
  // EMPTY | table not built; entry writes accepted, lookups blocked
  // BUILD | prefix sum walks one entry per cycle; writes and commits ignored
  // READY | table built; lookups enabled
  localparam int DEPTH     = 1 << SYM_WIDTH;
  localparam int SUM_WIDTH = SYM_WIDTH + CNT_WIDTH;

  typedef enum logic [1:0] {EMPTY, BUILD, READY} state_t;
  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0]   cnt_mem [DEPTH];
  logic [SUM_WIDTH-1:0]   cum_mem [DEPTH];
  logic [SUM_WIDTH-1:0]   run_sum, total_sum;
  logic [SYM_WIDTH-1:0]   idx;
  logic                   bubble, out_vld_q;
  logic [CNT_WIDTH-1:0]   s_count_q;
  logic [SUM_WIDTH-1:0]   s_cum_q;
  logic [STATE_WIDTH-1:0] total_q;
  logic                   wr_ok, build_start, build_last, in_fire, out_fire, zero_hit;

  assign wr_ok      = ena && cfg_we && (state != BUILD);
  assign build_last = (state == BUILD) && (&idx);
  assign in_rdy     = (state == READY) && !out_vld_q && !bubble;
  assign in_fire    = ena && in_vld && in_rdy;
  assign out_fire   = ena && out_vld_q && out_rdy;

  assign table_ok     = (state == READY);
  assign out_vld      = out_vld_q;
  assign s_count      = s_count_q;
  assign s_cumulative = s_cum_q;
  assign total_count  = total_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else if (ena) state <= state_nxt;
  end

  // A commit in READY waits for the output register to drain; a write there invalidates the table.
  always_comb begin
    state_nxt   = state;
    build_start = 1'b0;
    case (state)
      EMPTY: if (cfg_commit) begin
        state_nxt   = BUILD;
        build_start = 1'b1;
      end
      BUILD: if (build_last) state_nxt = READY;
      READY: begin
        if (cfg_commit && !out_vld_q) begin
          state_nxt   = BUILD;
          build_start = 1'b1;
        end else if (cfg_we) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_mem[i] <= '0;
        cum_mem[i] <= '0;
      end
      run_sum   <= '0;
      total_sum <= '0;
      idx       <= '0;
    end else if (ena) begin
      if (wr_ok) cnt_mem[cfg_sym] <= cfg_count;
      if (build_start) begin
        run_sum <= '0;
        idx     <= '0;
      end else if (state == BUILD) begin
        cum_mem[idx] <= run_sum;
        run_sum      <= run_sum + SUM_WIDTH'(cnt_mem[idx]);
        idx          <= idx + SYM_WIDTH'(1);
        if (build_last) total_sum <= run_sum + SUM_WIDTH'(cnt_mem[idx]);
      end
    end
  end

  // Data fields are only loaded on a lookup, so they hold through out_vld and the bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      bubble    <= 1'b0;
      s_count_q <= '0;
      s_cum_q   <= '0;
      total_q   <= '0;
    end else if (ena) begin
      if (bubble) bubble <= 1'b0;
      if (out_fire) begin
        out_vld_q <= 1'b0;
        bubble    <= 1'b1;
      end else if (in_fire && !zero_hit) begin
        out_vld_q <= 1'b1;
        s_count_q <= cnt_mem[in_sym];
        s_cum_q   <= cum_mem[in_sym];
        total_q   <= STATE_WIDTH'(total_sum);
      end
    end
  end

`ifdef ANS_FREQ_ZERO_CHECK_EN
  logic err_zero_q;

  assign zero_hit = (cnt_mem[in_sym] == '0);
  assign err_zero = err_zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_zero_q <= 1'b0;
    else if (in_fire && zero_hit) err_zero_q <= 1'b1;
  end
`else
  assign zero_hit = 1'b0;
  assign err_zero = 1'b0;
`endif

endmodule

// File: tb/tb_ans_freq_table.sv
// Self-checking bench for ans_freq_table: vector table plus output scoreboard.
module tb_ans_freq_table;
  localparam int SW = 4, CW = 8, TW = 16, N = 16;

  logic clk = 1'b0;
  logic rst, ena, cfg_we, cfg_commit, in_vld, out_rdy;
  logic [SW-1:0] cfg_sym, in_sym;
  logic [CW-1:0] cfg_count;
  logic table_ok, in_rdy, out_vld, err_zero;
  logic [CW-1:0] s_count;
  logic [SW+CW-1:0] s_cumulative;
  logic [TW-1:0] total_count;

  int errors = 0;
  int checks = 0;
  int model_cnt [N];

  typedef struct { int cnt; int cum; int tot; } exp_t;
  typedef struct { int sym; int cnt; int cum; int tot; } vec_t;
  exp_t sb [$];
  vec_t vecs [5];

  ans_freq_table #(.SYM_WIDTH(SW), .CNT_WIDTH(CW), .STATE_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .cfg_we(cfg_we), .cfg_sym(cfg_sym), .cfg_count(cfg_count), .cfg_commit(cfg_commit),
    .table_ok(table_ok),
    .in_sym(in_sym), .in_vld(in_vld), .in_rdy(in_rdy),
    .s_count(s_count), .s_cumulative(s_cumulative), .total_count(total_count),
    .out_vld(out_vld), .out_rdy(out_rdy), .err_zero(err_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int sym);
    exp_t e;
    e.cum = 0;
    e.tot = 0;
    for (int i = 0; i < N; i++) begin
      if (i < sym) e.cum += model_cnt[i];
      e.tot += model_cnt[i];
    end
    e.cnt = model_cnt[sym];
    return e;
  endfunction

  // Handshakes seen at the falling edge complete at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ena) begin
      if (in_vld && in_rdy) begin
        e = model(int'(in_sym));
`ifdef ANS_FREQ_ZERO_CHECK_EN
        if (e.cnt != 0) sb.push_back(e);
`else
        sb.push_back(e);
`endif
      end
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got an output, want none pending");
        end else begin
          e = sb.pop_front();
          check("sb_count", 32'(s_count), 32'(e.cnt));
          check("sb_cum", 32'(s_cumulative), 32'(e.cum));
          check("sb_total", 32'(total_count), 32'(e.tot));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int sym, input int val);
    cfg_we = 1'b1;
    cfg_sym = SW'(sym);
    cfg_count = CW'(val);
    tick();
    cfg_we = 1'b0;
    model_cnt[sym] = val;
  endtask

  task automatic commit_wait(input int exp_n, input bit gate, input string name);
    int n;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    n = 1;
    while (!table_ok && n < 100) begin
      if (gate && n == 3) begin
        ena = 1'b0;
        repeat (4) begin
          tick();
          n++;
        end
        ena = 1'b1;
      end else begin
        tick();
        n++;
      end
    end
    check(name, 32'(n), 32'(exp_n));
  endtask

  task automatic lookup(input int sym);
    int n = 0;
    while (!in_rdy && n < 50) begin
      tick();
      n++;
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("FAIL in_rdy_timeout: got in_rdy=0, want 1 within 50 cycles");
    end
    in_vld = 1'b1;
    in_sym = SW'(sym);
    tick();
    in_vld = 1'b0;
  endtask

  initial begin
    vecs[0] = '{sym: 3,  cnt: 4,  cum: 6,   tot: 136};
    vecs[1] = '{sym: 0,  cnt: 1,  cum: 0,   tot: 136};
    vecs[2] = '{sym: 7,  cnt: 8,  cum: 28,  tot: 136};
    vecs[3] = '{sym: 10, cnt: 11, cum: 55,  tot: 136};
    vecs[4] = '{sym: 15, cnt: 16, cum: 120, tot: 136};
    for (int i = 0; i < N; i++) model_cnt[i] = 0;

    rst = 1'b1; ena = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0; cfg_sym = '0; cfg_count = '0;
    in_vld = 1'b0; in_sym = '0; out_rdy = 1'b1;
    tick();
    tick();
    check("rst_table_ok", 32'(table_ok), 0);
    check("rst_in_rdy", 32'(in_rdy), 0);
    check("rst_out_vld", 32'(out_vld), 0);
    check("rst_s_count", 32'(s_count), 0);
    check("rst_s_cum", 32'(s_cumulative), 0);
    check("rst_total", 32'(total_count), 0);
    check("rst_err_zero", 32'(err_zero), 0);
    rst = 1'b0;
    tick();

    // Build with counts 1..16
    for (int i = 0; i < N; i++) cfg_write(i, i + 1);
    check("empty_in_rdy", 32'(in_rdy), 0);
    commit_wait(17, 1'b0, "build_latency");

    for (int v = 0; v < 5; v++) begin
      lookup(vecs[v].sym);
      check("vec_out_vld", 32'(out_vld), 1);
      check("vec_count", 32'(s_count), 32'(vecs[v].cnt));
      check("vec_cum", 32'(s_cumulative), 32'(vecs[v].cum));
      check("vec_total", 32'(total_count), 32'(vecs[v].tot));
      tick();
      check("vec_bubble", 32'(out_vld), 0);
      tick();
    end

    // Backpressure on sym 15
    out_rdy = 1'b0;
    lookup(15);
    for (int c = 0; c < 5; c++) begin
      check("bp_out_vld", 32'(out_vld), 1);
      check("bp_cum", 32'(s_cumulative), 120);
      check("bp_in_rdy", 32'(in_rdy), 0);
      tick();
    end
    out_rdy = 1'b1;
    tick();
    check("bp_bubble_vld", 32'(out_vld), 0);
    check("bp_bubble_rdy", 32'(in_rdy), 0);
    check("bp_bubble_cum", 32'(s_cumulative), 120);
    tick();
    check("bp_rdy_again", 32'(in_rdy), 1);

    // Reconfiguration while READY
    cfg_write(2, 9);
    check("recfg_table_ok", 32'(table_ok), 0);
    check("recfg_in_rdy", 32'(in_rdy), 0);
    repeat (3) tick();
    check("recfg_hold_ok", 32'(table_ok), 0);
    commit_wait(17, 1'b0, "recfg_latency");
    lookup(3);
    check("recfg_cum", 32'(s_cumulative), 12);
    check("recfg_total", 32'(total_count), 142);
    tick();
    tick();

    // Zero-frequency symbol
    cfg_write(5, 0);
    commit_wait(17, 1'b0, "zero_latency");
    lookup(5);
`ifdef ANS_FREQ_ZERO_CHECK_EN
    check("zero_out_vld", 32'(out_vld), 0);
    check("zero_err", 32'(err_zero), 1);
`else
    check("zero_out_vld", 32'(out_vld), 1);
    check("zero_count", 32'(s_count), 0);
    check("zero_cum", 32'(s_cumulative), 21);
    check("zero_err", 32'(err_zero), 0);
`endif
    tick();
    tick();

    // Reset midway through BUILD
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_table_ok", 32'(table_ok), 0);
    check("mid_rst_in_rdy", 32'(in_rdy), 0);
    check("mid_rst_out_vld", 32'(out_vld), 0);
    check("mid_rst_s_count", 32'(s_count), 0);
    check("mid_rst_s_cum", 32'(s_cumulative), 0);
    check("mid_rst_total", 32'(total_count), 0);
    check("mid_rst_err", 32'(err_zero), 0);
    sb.delete();
    for (int i = 0; i < N; i++) model_cnt[i] = 0;
    tick();
    rst = 1'b0;
    in_vld = 1'b1;
    in_sym = 4'd3;
    for (int c = 0; c < 4; c++) begin
      check("post_rst_in_rdy", 32'(in_rdy), 0);
      tick();
    end
    in_vld = 1'b0;
    check("post_rst_out_vld", 32'(out_vld), 0);

    // Enable gating during BUILD
    for (int i = 0; i < N; i++) cfg_write(i, i + 1);
    commit_wait(21, 1'b1, "gated_latency");
    lookup(15);
    check("gated_cum", 32'(s_cumulative), 120);
    check("gated_total", 32'(total_count), 136);
    tick();
    tick();

    check("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish within 200000 time units");
    $fatal(1);
  end
endmodule
